spi_regfile_peripheral: RTL and testbench

Parametrised SPI mode-0 target that writes and reads back a bank of `NUM_REGS` registers of `DATA_W` bits each, replacing the fixed 5 × 8-bit write-only peripheral. One frame carries command, address and data, with read data returned on CIPO within the same frame. All SPI pins are synchronised into `clk`, and the register bank drives the PWM/output-enable logic downstream.

---
 rtl/spi_regfile_peripheral.sv | 151 +++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target: frame = R/W bit, address, data (MSB first); writes commit on ncs rise,
// reads shift the addressed register out on cipo in the same frame. All pins synchronised into clk.
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA0 = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, COMMIT} state_t;
  state_t state, state_nxt;

  // {ncs, sclk, copi}; ncs resets high so reset release never fakes an edge
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] hist_q;
  logic [2:0] sync_last;
  logic       sclk_rise, sclk_fall, ncs_fall, ncs_rise;
  logic       copi_s;

  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] sh;
  logic [DATA_W-1:0]  out_sh;
  logic               rd_q;
  logic [ADDR_W:0]    hdr_now;
  logic [DATA_W-1:0]  rd_val;
  logic               frm_rw;
  logic [ADDR_W-1:0]  frm_addr;
  logic [DATA_W-1:0]  frm_data;
  logic               frame_start;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign copi_s    = hist_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
      hist_q    <= 3'b100;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ncs_fall  <= 1'b0;
      ncs_rise  <= 1'b0;
    end else begin
      sync_q[0] <= {ncs, sclk, copi};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q    <= sync_last;
      // sclk activity only counts while the synchronised select is low
      sclk_rise <= sync_last[1] & ~hist_q[1] & ~sync_last[2];
      sclk_fall <= ~sync_last[1] & hist_q[1] & ~sync_last[2];
      ncs_fall  <= ~sync_last[2] & hist_q[2];
      ncs_rise  <= sync_last[2] & ~hist_q[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ncs_fall) state_nxt = HDR;
      HDR:     if (sclk_rise && cnt == CNT_HDR) state_nxt = DATA;
      DATA:    state_nxt = DATA;
      COMMIT:  state_nxt = ncs_fall ? HDR : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ncs_rise) state_nxt = COMMIT;
  end

  assign hdr_now     = {sh[ADDR_W-1:0], copi_s};
  assign frm_rw      = sh[FRAME_W-1];
  assign frm_addr    = sh[DATA_W +: ADDR_W];
  assign frm_data    = sh[DATA_W-1:0];
  assign frame_start = ncs_fall && (state == IDLE || state == COMMIT);

  // Unimplemented addresses read back as zero
  always_comb begin
    rd_val = '0;
    for (int n = 0; n < NUM_REGS; n++)
      if (hdr_now[ADDR_W-1:0] == ADDR_W'(n)) rd_val = regs_out[n*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sh        <= '0;
      out_sh    <= '0;
      rd_q      <= 1'b0;
      regs_out  <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise) begin
        if (cnt == CNT_FRAME) begin
          if (frm_rw) begin
            for (int n = 0; n < NUM_REGS; n++) begin
              if (frm_addr == ADDR_W'(n)) begin
                regs_out[n*DATA_W +: DATA_W] <= frm_data;
                wr_strobe <= 1'b1;
                wr_addr   <= frm_addr;
              end
            end
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else if (frame_start) begin
        cnt    <= '0;
        sh     <= '0;
        out_sh <= '0;
        rd_q   <= 1'b0;
      end else if (sclk_rise && (state == HDR || state == DATA)) begin
        sh <= {sh[FRAME_W-2:0], copi_s};
        if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
        if (state == HDR && cnt == CNT_HDR) begin
          rd_q   <= ~hdr_now[ADDR_W];
          out_sh <= rd_val;
        end
      end else if (sclk_fall && state == DATA && cnt != CNT_DATA0) begin
        // The fall before the first data rise keeps the MSB on the wire
        out_sh <= out_sh << 1;
      end
    end
  end

  assign cipo_oe = (state == DATA) && rd_q;
  assign cipo    = cipo_oe & out_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench: two peripherals (5x8 and 16x12) share sclk/copi with separate selects;
// stimulus pushes expected commits/read words, one monitor pops and compares.
module tb_spi_regfile_peripheral;
  logic clk = 1'b0;
  logic rst_n, sclk, copi, ncs_a, ncs_b;
  logic cipo_a, cipo_oe_a, wr_strobe_a, frame_err_a;
  logic cipo_b, cipo_oe_b, wr_strobe_b, frame_err_b;
  logic [39:0]  regs_a;
  logic [191:0] regs_b;
  logic [6:0]   wr_addr_a, wr_addr_b;

  always #5 clk = ~clk;

  spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs_a),
    .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_out(regs_a),
    .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a));

  spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(12), .ADDR_W(7), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs_b),
    .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_out(regs_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b));

  typedef struct {
    bit           err;
    bit [6:0]     addr;
    bit [191:0]   regs;
  } ev_t;

  ev_t         ev_qa[$], ev_qb[$];
  logic [11:0] rd_qa[$], rd_qb[$];
  logic [11:0] mdl [2][16];
  logic [6:0]  last_addr [2];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        rst_chk = 1'b1;
  logic        done = 1'b0;

  function automatic void check(string nm, logic [255:0] got, logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic logic [191:0] regs_vec(bit d);
    logic [191:0] v = '0;
    for (int n = 0; n < 16; n++) begin
      if (d) v[n*12 +: 12] = mdl[1][n];
      else if (n < 5) v[n*8 +: 8] = mdl[0][n][7:0];
    end
    return v;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ncs(bit d, logic v);
    if (d) ncs_b = v;
    else   ncs_a = v;
  endtask

  task automatic shift_bit(logic b);
    copi = b;
    tick(8);
    sclk = 1'b1;
    tick(8);
    sclk = 1'b0;
  endtask

  // delta: 0 = well-formed frame, -1 = one bit short, +1 = one bit long
  task automatic spi_frame(bit d, bit rw, logic [6:0] addr, logic [11:0] data, int delta);
    int          nr, fw, n;
    logic [31:0] v;
    ev_t         e;
    nr = d ? 16 : 5;
    fw = d ? 20 : 16;
    v  = d ? {12'b0, rw, addr, data} : {16'b0, rw, addr, data[7:0]};
    n  = fw + delta;
    if (delta < 0) v = v >> 1;
    else if (delta > 0) v = v << 1;
    if (delta != 0) begin
      e.err = 1'b1; e.addr = last_addr[d]; e.regs = regs_vec(d);
      if (d) ev_qb.push_back(e); else ev_qa.push_back(e);
    end else if (rw) begin
      if (int'(addr) < nr) begin
        mdl[d][addr[3:0]] = d ? data : {4'b0, data[7:0]};
        last_addr[d] = addr;
        e.err = 1'b0; e.addr = addr; e.regs = regs_vec(d);
        if (d) ev_qb.push_back(e); else ev_qa.push_back(e);
      end
    end else begin
      if (d) rd_qb.push_back(int'(addr) < nr ? mdl[1][addr[3:0]] : 12'h000);
      else   rd_qa.push_back(int'(addr) < nr ? mdl[0][addr[3:0]] : 12'h000);
    end
    set_ncs(d, 1'b0);
    tick(8);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    tick(8);
    set_ncs(d, 1'b1);
    copi = 1'b0;
    tick(12);
  endtask

  // Monitor: the only process that compares
  logic       sclk_q = 1'b0, oe_a_q = 1'b0, oe_b_q = 1'b0, done_q = 1'b0;
  logic [7:0] bits_a = 0, bits_b = 0;
  logic [11:0] word_a = 0, word_b = 0;
  always @(negedge clk) begin
    ev_t         e;
    logic [11:0] rexp;
    if (rst_chk) begin
      check("reset_a", {regs_a, wr_addr_a, cipo_a, cipo_oe_a, wr_strobe_a, frame_err_a}, '0);
      check("reset_b", {regs_b, wr_addr_b, cipo_b, cipo_oe_b, wr_strobe_b, frame_err_b}, '0);
    end
    if (wr_strobe_a || frame_err_a) begin
      if (ev_qa.size() == 0) check("a_unexpected_pulse", {wr_strobe_a, frame_err_a}, '0);
      else begin
        e = ev_qa.pop_front();
        check("a_commit", {frame_err_a, wr_strobe_a, wr_addr_a, regs_a},
              {e.err, ~e.err, e.addr, e.regs[39:0]});
      end
    end
    if (wr_strobe_b || frame_err_b) begin
      if (ev_qb.size() == 0) check("b_unexpected_pulse", {wr_strobe_b, frame_err_b}, '0);
      else begin
        e = ev_qb.pop_front();
        check("b_commit", {frame_err_b, wr_strobe_b, wr_addr_b, regs_b},
              {e.err, ~e.err, e.addr, e.regs});
      end
    end
    if (!cipo_oe_a && cipo_a) check("a_cipo_idle", cipo_a, 1'b0);
    if (!cipo_oe_b && cipo_b) check("b_cipo_idle", cipo_b, 1'b0);
    if (cipo_oe_a && !oe_a_q) begin bits_a = 0; word_a = 0; end
    if (cipo_oe_b && !oe_b_q) begin bits_b = 0; word_b = 0; end
    if (sclk && !sclk_q && cipo_oe_a) begin word_a = {word_a[10:0], cipo_a}; bits_a++; end
    if (sclk && !sclk_q && cipo_oe_b) begin word_b = {word_b[10:0], cipo_b}; bits_b++; end
    if (!cipo_oe_a && oe_a_q) begin
      if (rd_qa.size() == 0) check("a_unexpected_read", 1'b1, 1'b0);
      else begin rexp = rd_qa.pop_front(); check("a_read", {bits_a, word_a}, {8'd8, rexp}); end
    end
    if (!cipo_oe_b && oe_b_q) begin
      if (rd_qb.size() == 0) check("b_unexpected_read", 1'b1, 1'b0);
      else begin rexp = rd_qb.pop_front(); check("b_read", {bits_b, word_b}, {8'd12, rexp}); end
    end
    if (done && !done_q) begin
      check("a_pending", ev_qa.size() + rd_qa.size(), 0);
      check("b_pending", ev_qb.size() + rd_qb.size(), 0);
    end
    sclk_q = sclk;
    oe_a_q = cipo_oe_a;
    oe_b_q = cipo_oe_b;
    done_q = done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      last_addr[d] = '0;
      for (int n = 0; n < 16; n++) mdl[d][n] = '0;
    end
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs_a = 1'b1; ncs_b = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(4);
    rst_chk = 1'b0;

    spi_frame(0, 1, 7'd3, 12'h0A5, 0);
    spi_frame(0, 0, 7'd3, 12'h000, 0);
    spi_frame(0, 1, 7'd0, 12'h05A, 0);
    spi_frame(0, 1, 7'd4, 12'h0FF, 0);
    spi_frame(0, 0, 7'd4, 12'h000, 0);
    spi_frame(0, 1, 7'd1, 12'h03C, -1);
    spi_frame(0, 1, 7'd1, 12'h03C, 1);
    spi_frame(0, 1, 7'd9, 12'h077, 0);
    spi_frame(0, 0, 7'd9, 12'h000, 0);
    spi_frame(0, 0, 7'd0, 12'h000, 0);

    spi_frame(1, 1, 7'd15, 12'hABC, 0);
    spi_frame(1, 0, 7'd15, 12'h000, 0);

    // Reset during the data phase of a write to the 16x12 bank
    ncs_b = 1'b0;
    tick(8);
    begin
      logic [19:0] part;
      part = {1'b1, 7'd15, 12'h555};
      for (int i = 19; i >= 8; i--) shift_bit(part[i]);
    end
    rst_n = 1'b0;
    sclk = 1'b0; copi = 1'b0; ncs_b = 1'b1;
    rst_chk = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last_addr[d] = '0;
      for (int n = 0; n < 16; n++) mdl[d][n] = '0;
    end
    tick(4);
    rst_n = 1'b1;
    tick(4);
    rst_chk = 1'b0;
    tick(8);

    spi_frame(1, 1, 7'd2, 12'h123, 0);
    spi_frame(1, 0, 7'd2, 12'h000, 0);
    spi_frame(1, 0, 7'd15, 12'h000, 0);

    done = 1'b1;
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
